// File: rtl/fb_scanout.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fb_scanout: VGA scanout of a 32x32 cell framebuffer through a 16-colour palette.
// Rev 1.0
// ----------------------------------------------------------------------------
module fb_scanout #(
  parameter int          PIX_DIV    = 2,
  parameter int          H_ACTIVE   = 640,
  parameter int          H_FP       = 16,
  parameter int          H_SYNC     = 96,
  parameter int          H_BP       = 48,
  parameter int          V_ACTIVE   = 480,
  parameter int          V_FP       = 10,
  parameter int          V_SYNC     = 2,
  parameter int          V_BP       = 33,
  parameter int          X_OFFSET   = 80,
  parameter int          CELL       = 15,
  parameter logic [23:0] BORDER_RGB = 24'h000000
) (
  input  logic       clock,
  input  logic       nreset,
  output logic [9:0] fb_addr,
  output logic       fb_rd,
  input  logic [7:0] fb_data,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic       frame_start
);

  localparam int c_HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int c_HW = $clog2(c_HT);
  localparam int c_VW = $clog2(c_VT);
  localparam int c_DW = $clog2(PIX_DIV);
  localparam int c_SW = (CELL > 1) ? $clog2(CELL) : 1;

  localparam logic [c_DW-1:0] c_DIV_LAST = c_DW'(PIX_DIV - 1);
  localparam logic [c_SW-1:0] c_SUB_LAST = c_SW'(CELL - 1);
  localparam logic [c_HW-1:0] c_H_LAST   = c_HW'(c_HT - 1);
  localparam logic [c_HW-1:0] c_H_ACT    = c_HW'(H_ACTIVE);
  localparam logic [c_HW-1:0] c_HS_BEG   = c_HW'(H_ACTIVE + H_FP);
  localparam logic [c_HW-1:0] c_HS_END   = c_HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [c_HW-1:0] c_PX_BEG   = c_HW'(X_OFFSET);
  localparam logic [c_HW-1:0] c_PX_END   = c_HW'(X_OFFSET + 32 * CELL - 1);
  localparam logic [c_VW-1:0] c_V_LAST   = c_VW'(c_VT - 1);
  localparam logic [c_VW-1:0] c_V_ACT    = c_VW'(V_ACTIVE);
  localparam logic [c_VW-1:0] c_VS_BEG   = c_VW'(V_ACTIVE + V_FP);
  localparam logic [c_VW-1:0] c_VS_END   = c_VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [c_DW-1:0] r_div;
  logic [c_HW-1:0] r_h;
  logic [c_VW-1:0] r_v;
  logic [4:0]      r_cell_x, r_cell_y;
  logic [c_SW-1:0] r_sub_x, r_sub_y;
  logic            r_s1_hs, r_s1_vs, r_s1_de, r_s1_pic;
  logic [9:0]      r_fb_addr;
  logic            r_fb_rd;
  logic            r_hsync, r_vsync, r_de, r_frame_start;
  logic [23:0]     r_rgb;

  logic        w_tick, w_h_wrap, w_v_wrap;
  logic        w_hs_raw, w_vs_raw, w_de_raw, w_pic_raw;
  logic [23:0] w_pal;
  logic [3:0]  w_unused_hi;

  assign w_unused_hi = fb_data[7:4];

  assign w_tick    = (r_div == c_DIV_LAST);
  assign w_h_wrap  = (r_h == c_H_LAST);
  assign w_v_wrap  = (r_v == c_V_LAST);
  assign w_hs_raw  = !((r_h >= c_HS_BEG) && (r_h <= c_HS_END));
  assign w_vs_raw  = !((r_v >= c_VS_BEG) && (r_v <= c_VS_END));
  assign w_de_raw  = (r_h < c_H_ACT) && (r_v < c_V_ACT);
  assign w_pic_raw = (r_h >= c_PX_BEG) && (r_h <= c_PX_END) && (r_v < c_V_ACT);

  always_comb begin
    w_pal = 24'h000000;
    case (fb_data[3:0])
      4'h0: w_pal = 24'h000000;
      4'h1: w_pal = 24'hFFFFFF;
      4'h2: w_pal = 24'h880000;
      4'h3: w_pal = 24'hAAFFEE;
      4'h4: w_pal = 24'hCC44CC;
      4'h5: w_pal = 24'h00CC55;
      4'h6: w_pal = 24'h0000AA;
      4'h7: w_pal = 24'hEEEE77;
      4'h8: w_pal = 24'hDD8855;
      4'h9: w_pal = 24'h664400;
      4'hA: w_pal = 24'hFF7777;
      4'hB: w_pal = 24'h333333;
      4'hC: w_pal = 24'h777777;
      4'hD: w_pal = 24'hAAFF66;
      4'hE: w_pal = 24'h0088FF;
      4'hF: w_pal = 24'hBBBBBB;
      default: w_pal = 24'h000000;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      r_div         <= '0;
      r_h           <= '0;
      r_v           <= '0;
      r_cell_x      <= '0;
      r_cell_y      <= '0;
      r_sub_x       <= '0;
      r_sub_y       <= '0;
      r_s1_hs       <= 1'b1;
      r_s1_vs       <= 1'b1;
      r_s1_de       <= 1'b0;
      r_s1_pic      <= 1'b0;
      r_fb_addr     <= '0;
      r_fb_rd       <= 1'b0;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_de          <= 1'b0;
      r_rgb         <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_fb_rd       <= w_tick && w_pic_raw;
      r_frame_start <= w_tick && w_h_wrap && w_v_wrap;
      r_div         <= w_tick ? '0 : r_div + c_DW'(1);

      if (w_tick) begin
        r_h <= w_h_wrap ? '0 : r_h + c_HW'(1);
        if (w_h_wrap)
          r_v <= w_v_wrap ? '0 : r_v + c_VW'(1);

        // Horizontal cell walk across the picture area, rewound just past its right edge
        if (r_h == c_PX_END) begin
          r_sub_x  <= '0;
          r_cell_x <= '0;
        end else if (w_pic_raw) begin
          if (r_sub_x == c_SUB_LAST) begin
            r_sub_x <= '0;
            if (r_cell_x != 5'd31)
              r_cell_x <= r_cell_x + 5'd1;
          end else begin
            r_sub_x <= r_sub_x + c_SW'(1);
          end
        end

        if (w_h_wrap) begin
          if (w_v_wrap) begin
            r_sub_y  <= '0;
            r_cell_y <= '0;
          end else if (r_v < c_V_ACT) begin
            if (r_sub_y == c_SUB_LAST) begin
              r_sub_y <= '0;
              if (r_cell_y != 5'd31)
                r_cell_y <= r_cell_y + 5'd1;
            end else begin
              r_sub_y <= r_sub_y + c_SW'(1);
            end
          end
        end

        r_fb_addr <= {r_cell_y, r_cell_x};
        r_s1_hs   <= w_hs_raw;
        r_s1_vs   <= w_vs_raw;
        r_s1_de   <= w_de_raw;
        r_s1_pic  <= w_pic_raw;

        // fb_data now holds the byte requested on the previous tick
        r_hsync <= r_s1_hs;
        r_vsync <= r_s1_vs;
        r_de    <= r_s1_de;
        if (!r_s1_de)
          r_rgb <= '0;
        else if (r_s1_pic)
          r_rgb <= w_pal;
        else
          r_rgb <= BORDER_RGB;
      end
    end
  end

  assign fb_addr     = r_fb_addr;
  assign fb_rd       = r_fb_rd;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign de          = r_de;
  assign red         = r_rgb[23:16];
  assign green       = r_rgb[15:8];
  assign blue        = r_rgb[7:0];
  assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_fb_scanout.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_fb_scanout: scoreboard bench for fb_scanout (full timing plus a scaled-down instance).
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_fb_scanout;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       nreset_a, nreset_b;
  logic [9:0] fb_addr_a, fb_addr_b;
  logic       fb_rd_a, fb_rd_b;
  logic [7:0] fb_data_a = 8'h00, fb_data_b = 8'h00;
  logic       hsync_a, vsync_a, de_a, fs_a;
  logic       hsync_b, vsync_b, de_b, fs_b;
  logic [7:0] red_a, green_a, blue_a, red_b, green_b, blue_b;

  fb_scanout #(.BORDER_RGB(24'h102030)) u_dut_a (
    .clock(clk), .nreset(nreset_a), .fb_addr(fb_addr_a), .fb_rd(fb_rd_a),
    .fb_data(fb_data_a), .hsync(hsync_a), .vsync(vsync_a), .de(de_a),
    .red(red_a), .green(green_a), .blue(blue_a), .frame_start(fs_a)
  );

  fb_scanout #(
    .PIX_DIV(3), .H_ACTIVE(48), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(32), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .X_OFFSET(8), .CELL(1), .BORDER_RGB(24'hA5A5A5)
  ) u_dut_b (
    .clock(clk), .nreset(nreset_b), .fb_addr(fb_addr_b), .fb_rd(fb_rd_b),
    .fb_data(fb_data_b), .hsync(hsync_b), .vsync(vsync_b), .de(de_b),
    .red(red_b), .green(green_b), .blue(blue_b), .frame_start(fs_b)
  );

  // Framebuffer models: byte at offset n is n[7:0]
  always @(posedge clk) if (fb_rd_a) fb_data_a <= fb_addr_a[7:0];
  always @(posedge clk) if (fb_rd_b) fb_data_b <= fb_addr_b[7:0];

  localparam int S_HS = 0, S_VS = 1, S_DE = 2, S_RGB = 3, S_RD = 4, S_ADDR = 5, S_FS = 6;

  typedef struct {
    int          cyc;
    int          dut;
    int          sig;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic void add(int c, int d, int s, logic [31:0] e, string n);
    exp_t x;
    x.cyc = c; x.dut = d; x.sig = s; x.exp = e; x.name = n;
    q.push_back(x);
  endfunction

  // Pixel p is in the counters from base+d*p, in stage 1 from base+d*(p+1), at the outputs from base+d*(p+2)
  function automatic int ts1(int base, int d, int p);
    return base + d * (p + 1);
  endfunction
  function automatic int tout(int base, int d, int p);
    return base + d * (p + 2);
  endfunction

  function automatic logic [31:0] act(int d, int s);
    logic [31:0] r;
    r = 32'hDEAD_BEEF;
    if (d == 0) begin
      case (s)
        S_HS:   r = {31'd0, hsync_a};
        S_VS:   r = {31'd0, vsync_a};
        S_DE:   r = {31'd0, de_a};
        S_RGB:  r = {8'd0, red_a, green_a, blue_a};
        S_RD:   r = {31'd0, fb_rd_a};
        S_ADDR: r = {22'd0, fb_addr_a};
        S_FS:   r = {31'd0, fs_a};
        default: r = 32'hDEAD_BEEF;
      endcase
    end else begin
      case (s)
        S_HS:   r = {31'd0, hsync_b};
        S_VS:   r = {31'd0, vsync_b};
        S_DE:   r = {31'd0, de_b};
        S_RGB:  r = {8'd0, red_b, green_b, blue_b};
        S_RD:   r = {31'd0, fb_rd_b};
        S_ADDR: r = {22'd0, fb_addr_b};
        S_FS:   r = {31'd0, fs_b};
        default: r = 32'hDEAD_BEEF;
      endcase
    end
    return r;
  endfunction

  // Monitor: pops every expectation due on this clock and compares it
  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc == cyc) begin
        logic [31:0] a;
        a = act(q[i].dut, q[i].sig);
        n_checks++;
        if (a !== q[i].exp) begin
          n_errors++;
          $display("FAIL %s: got %0h expected %0h (cycle %0d)", q[i].name, a, q[i].exp, cyc);
        end
        q.delete(i);
      end
    end
  end

  localparam int BA = 5;          // last reset edge, both instances
  localparam int DA = 2, LA = 800;
  localparam int DB = 3, LB = 56;
  localparam int B2 = BA + DB * LB * 38;  // second frame of instance B
  localparam int BR = 9840;       // mid-frame reset edge of instance B

  initial begin
    nreset_a = 1'b0;
    nreset_b = 1'b0;

    for (int c = 1; c <= 5; c++) begin
      add(c, 0, S_HS, 1, "rst_hsync");
      add(c, 0, S_VS, 1, "rst_vsync");
      add(c, 0, S_DE, 0, "rst_de");
      add(c, 0, S_RGB, 0, "rst_rgb");
      add(c, 0, S_RD, 0, "rst_fb_rd");
    end

    // Instance A: full 640x480 timing, first lines only
    add(ts1(BA, DA, 0), 0, S_FS, 0, "a_fs_idle");
    add(tout(BA, DA, 655), 0, S_HS, 1, "a_hs_655");
    add(tout(BA, DA, 656), 0, S_HS, 0, "a_hs_656");
    add(tout(BA, DA, 751), 0, S_HS, 0, "a_hs_751");
    add(tout(BA, DA, 752), 0, S_HS, 1, "a_hs_752");
    add(tout(BA, DA, LA + 655), 0, S_HS, 1, "a_hs_l1_655");
    add(tout(BA, DA, LA + 656), 0, S_HS, 0, "a_hs_l1_656");
    add(tout(BA, DA, 0), 0, S_VS, 1, "a_vs_0");
    add(tout(BA, DA, 0), 0, S_DE, 1, "a_de_0");
    add(tout(BA, DA, 0), 0, S_RGB, 24'h102030, "a_border_0");
    add(tout(BA, DA, 79), 0, S_RGB, 24'h102030, "a_border_79");
    add(tout(BA, DA, 80), 0, S_RGB, 24'h000000, "a_pic_80");
    add(tout(BA, DA, 95), 0, S_RGB, 24'hFFFFFF, "a_pic_95");
    add(tout(BA, DA, 545), 0, S_RGB, 24'hBBBBBB, "a_pic_545");
    add(tout(BA, DA, 559), 0, S_RGB, 24'hBBBBBB, "a_pic_559");
    add(tout(BA, DA, 560), 0, S_RGB, 24'h102030, "a_border_560");
    add(tout(BA, DA, 639), 0, S_RGB, 24'h102030, "a_border_639");
    add(tout(BA, DA, 639), 0, S_DE, 1, "a_de_639");
    add(tout(BA, DA, 640), 0, S_DE, 0, "a_de_640");
    add(tout(BA, DA, 640), 0, S_RGB, 0, "a_blank_640");
    add(tout(BA, DA, 700), 0, S_DE, 0, "a_de_700");
    add(tout(BA, DA, 700), 0, S_RGB, 0, "a_blank_700");
    add(ts1(BA, DA, 79), 0, S_RD, 0, "a_rd_79");
    add(ts1(BA, DA, 80), 0, S_RD, 1, "a_rd_80");
    add(ts1(BA, DA, 80) + 1, 0, S_RD, 0, "a_rd_pulse");
    add(ts1(BA, DA, 80), 0, S_ADDR, 0, "a_addr_80");
    add(ts1(BA, DA, 94), 0, S_ADDR, 0, "a_addr_94");
    add(ts1(BA, DA, 95), 0, S_ADDR, 1, "a_addr_95");
    add(ts1(BA, DA, 545), 0, S_ADDR, 31, "a_addr_545");
    add(ts1(BA, DA, 559), 0, S_ADDR, 31, "a_addr_559");
    add(ts1(BA, DA, 559), 0, S_RD, 1, "a_rd_559");
    add(ts1(BA, DA, 560), 0, S_RD, 0, "a_rd_560");
    add(ts1(BA, DA, 14 * LA + 559), 0, S_ADDR, 31, "a_addr_l14_end");
    add(ts1(BA, DA, 15 * LA + 80), 0, S_ADDR, 32, "a_addr_l15_start");
    add(tout(BA, DA, 15 * LA + 110), 0, S_RGB, 24'h880000, "a_pal_022");

    // Instance B: 56x38 scaled timing, 1-pixel cells, PIX_DIV=3
    add(ts1(BA, DB, 8), 1, S_ADDR, 0, "b_addr_first");
    add(ts1(BA, DB, 8), 1, S_RD, 1, "b_rd_first");
    add(ts1(BA, DB, 39), 1, S_ADDR, 31, "b_addr_39");
    add(ts1(BA, DB, 40), 1, S_RD, 0, "b_rd_40");
    add(ts1(BA, DB, 7 * LB + 25), 1, S_ADDR, 241, "b_addr_0f1");
    add(ts1(BA, DB, 31 * LB + 39), 1, S_ADDR, 1023, "b_addr_last");
    add(tout(BA, DB, 5), 1, S_RGB, 24'hA5A5A5, "b_border_5");
    add(tout(BA, DB, 7 * LB + 25), 1, S_RGB, 24'hFFFFFF, "b_pal_0f1");
    add(tout(BA, DB, 31 * LB + 31), 1, S_RGB, 24'hEEEE77, "b_pal_3f7");
    add(tout(BA, DB, 40), 1, S_RGB, 24'hA5A5A5, "b_border_40");
    add(tout(BA, DB, 47), 1, S_DE, 1, "b_de_47");
    add(tout(BA, DB, 48), 1, S_DE, 0, "b_de_48");
    add(tout(BA, DB, 48), 1, S_RGB, 0, "b_blank_48");
    add(tout(BA, DB, 49), 1, S_HS, 1, "b_hs_49");
    add(tout(BA, DB, 50), 1, S_HS, 0, "b_hs_50");
    add(tout(BA, DB, 53), 1, S_HS, 0, "b_hs_53");
    add(tout(BA, DB, 54), 1, S_HS, 1, "b_hs_54");
    add(tout(BA, DB, 33 * LB + 55), 1, S_VS, 1, "b_vs_l33");
    add(tout(BA, DB, 34 * LB), 1, S_VS, 0, "b_vs_l34");
    add(tout(BA, DB, 35 * LB + 55), 1, S_VS, 0, "b_vs_l35");
    add(tout(BA, DB, 36 * LB), 1, S_VS, 1, "b_vs_l36");
    add(B2 - 1, 1, S_FS, 0, "b_fs_before");
    add(B2, 1, S_FS, 1, "b_fs_pulse");
    add(B2 + 1, 1, S_FS, 0, "b_fs_after");
    add(ts1(B2, DB, 20 * LB + 29), 1, S_ADDR, 661, "b_addr_prereset");
    add(ts1(B2, DB, 20 * LB + 29), 1, S_RD, 1, "b_rd_prereset");
    add(BR, 1, S_HS, 1, "b_mid_hsync");
    add(BR, 1, S_VS, 1, "b_mid_vsync");
    add(BR, 1, S_DE, 0, "b_mid_de");
    add(BR, 1, S_RGB, 0, "b_mid_rgb");
    add(BR, 1, S_RD, 0, "b_mid_fb_rd");
    add(BR, 1, S_ADDR, 0, "b_mid_fb_addr");
    add(BR, 1, S_FS, 0, "b_mid_fs");
    add(ts1(BR, DB, 8), 1, S_ADDR, 0, "b_restart_addr");
    add(ts1(BR, DB, 8), 1, S_RD, 1, "b_restart_rd");
    add(tout(BR, DB, 49), 1, S_HS, 1, "b_restart_hs_49");
    add(tout(BR, DB, 50), 1, S_HS, 0, "b_restart_hs_50");
    add(B2 + DB * LB * 38, 1, S_FS, 0, "b_fs_old_schedule");
    add(BR + DB * LB * 38 - 1, 1, S_FS, 0, "b_fs_restart_before");
    add(BR + DB * LB * 38, 1, S_FS, 1, "b_fs_restart");

    while (cyc < BA) @(negedge clk);

    n_checks++;
    if (hsync_a !== 1'b1) begin
      n_errors++;
      $display("FAIL hold_hsync: got %0b expected 1", hsync_a);
    end
    n_checks++;
    if (vsync_a !== 1'b1) begin
      n_errors++;
      $display("FAIL hold_vsync: got %0b expected 1", vsync_a);
    end
    n_checks++;
    if (de_a !== 1'b0) begin
      n_errors++;
      $display("FAIL hold_de: got %0b expected 0", de_a);
    end
    n_checks++;
    if (fb_rd_a !== 1'b0) begin
      n_errors++;
      $display("FAIL hold_fb_rd: got %0b expected 0", fb_rd_a);
    end
    n_checks++;
    if ({red_a, green_a, blue_a} !== 24'h000000) begin
      n_errors++;
      $display("FAIL hold_rgb: got %0h expected 0", {red_a, green_a, blue_a});
    end

    nreset_a = 1'b1;
    nreset_b = 1'b1;

    while (cyc < BR - 1) @(negedge clk);
    nreset_b = 1'b0;
    @(negedge clk);
    nreset_b = 1'b1;

    while (cyc < 24400) @(negedge clk);

    foreach (q[i]) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: never sampled, expected %0h at cycle %0d", q[i].name, q[i].exp, q[i].cyc);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
